// File: rtl/core6_cpu_0_dct_trace_arbiter.sv
// Round-robin arbiter that collects per-core DCT trace frames and forwards
// them one at a time to a single trace sink, with saturation and flush drain.
module core6_cpu_0_dct_trace_arbiter #(
  parameter int NUM_CORES = 6,
  parameter int DCT_W     = 30,
  parameter int CNT_W     = 4,
  parameter int MAX_COUNT = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CORES-1:0]       req,
  input  logic [NUM_CORES*DCT_W-1:0] req_buffer,
  input  logic [NUM_CORES*CNT_W-1:0] req_count,
  output logic [NUM_CORES-1:0]       ack,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DCT_W-1:0]           out_buffer,
  output logic [CNT_W-1:0]           out_count,
  output logic [2:0]                 out_core,
  input  logic                       flush,
  output logic                       flushed,
  output logic                       sat_err,
  output logic [15:0]                frame_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [2:0]       last_grant;
  logic             flush_pend;

  logic [7:0]       req_pad;
  logic [3:0]       cand;
  logic             sel_found;
  logic [2:0]       sel_idx;
  logic [DCT_W-1:0] sel_buffer;
  logic [CNT_W-1:0] sel_count;
  logic             sat_hit;
  logic [CNT_W-1:0] sel_clamped;

  // Search starts one past the last grant and wraps at NUM_CORES, so the
  // most recently served core has the lowest priority next time.
  // NOTE: every combinational output gets a default first; otherwise a path
  // that skips the assignment infers a latch.
  always_comb begin
    req_pad                 = '0;
    req_pad[NUM_CORES-1:0]  = req;
    cand                    = '0;
    sel_found               = 1'b0;
    sel_idx                 = '0;
    for (int k = 1; k <= NUM_CORES; k++) begin
      cand = {1'b0, last_grant} + 4'(k);
      if (cand >= 4'(NUM_CORES)) cand = cand - 4'(NUM_CORES);
      if (!sel_found && req_pad[cand[2:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[2:0];
      end
    end
  end

  assign sel_buffer  = req_buffer[sel_idx*DCT_W +: DCT_W];
  assign sel_count   = req_count[sel_idx*CNT_W +: CNT_W];
  assign sat_hit     = sel_count > CNT_W'(MAX_COUNT);
  assign sel_clamped = sat_hit ? CNT_W'(MAX_COUNT) : sel_count;

  // NOTE: registered state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 3'(NUM_CORES - 1);
      flush_pend <= 1'b0;
      ack        <= '0;
      out_valid  <= 1'b0;
      out_buffer <= '0;
      out_count  <= '0;
      out_core   <= '0;
      flushed    <= 1'b0;
      sat_err    <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      ack <= '0;
      if (flush) flush_pend <= 1'b1;
      case (state)
        IDLE: begin
          if (sel_found) begin
            ack        <= NUM_CORES'(1) << sel_idx;
            last_grant <= sel_idx;
            out_buffer <= sel_buffer;
            out_count  <= sel_clamped;
            out_core   <= sel_idx;
            if (sat_hit) sat_err <= 1'b1;
            // An empty frame is acknowledged but never offered to the sink.
            if (sel_count != '0) begin
              out_valid <= 1'b1;
              state     <= SEND;
            end
          end else if (flush_pend) begin
            flushed <= 1'b1;
            state   <= DONE;
          end
        end
        SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            frame_cnt <= frame_cnt + 16'd1;
            state     <= IDLE;
          end
        end
        DONE: begin
          flushed <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core6_cpu_0_dct_trace_arbiter.sv
// Self-checking bench: a frame-level reference model is compared against the
// arbiter every cycle, plus directed scenarios with literal expectations.
module tb_core6_cpu_0_dct_trace_arbiter;

  localparam int N    = 6;
  localparam int DW   = 30;
  localparam int CW   = 4;
  localparam int MAXC = 10;

  logic            clk        = 1'b0;
  logic            reset      = 1'b1;
  logic [N-1:0]    req        = '0;
  logic [N*DW-1:0] req_buffer = '0;
  logic [N*CW-1:0] req_count  = '0;
  logic            out_ready  = 1'b0;
  logic            flush      = 1'b0;
  logic [N-1:0]    ack;
  logic            out_valid;
  logic [DW-1:0]   out_buffer;
  logic [CW-1:0]   out_count;
  logic [2:0]      out_core;
  logic            flushed;
  logic            sat_err;
  logic [15:0]     frame_cnt;

  always #5 clk = ~clk;

  core6_cpu_0_dct_trace_arbiter #(
    .NUM_CORES(N), .DCT_W(DW), .CNT_W(CW), .MAX_COUNT(MAXC)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_buffer(req_buffer),
    .req_count(req_count), .ack(ack), .out_valid(out_valid),
    .out_ready(out_ready), .out_buffer(out_buffer), .out_count(out_count),
    .out_core(out_core), .flush(flush), .flushed(flushed),
    .sat_err(sat_err), .frame_cnt(frame_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model (frame level) ----------------
  bit            m_live = 1'b0;
  bit            m_busy, m_done, m_pend, m_sat;
  int            m_lg, m_core, m_sel, m_c;
  logic [N-1:0]  m_ack;
  logic [DW-1:0] m_buf;
  logic [CW-1:0] m_cnt;
  logic [15:0]   m_frames;

  function automatic int rr_pick(input logic [N-1:0] r, input int lg);
    for (int k = 1; k <= N; k++)
      if (r[(lg + k) % N]) return (lg + k) % N;
    return -1;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_live = 1'b1; m_busy = 1'b0; m_done = 1'b0; m_pend = 1'b0; m_sat = 1'b0;
      m_lg = N - 1; m_core = 0; m_ack = '0; m_buf = '0; m_cnt = '0; m_frames = '0;
    end else if (m_live) begin
      m_ack = '0;
      if (m_done) begin
        m_ack = '0;
      end else if (m_busy) begin
        if (out_ready) begin
          m_busy   = 1'b0;
          m_frames = m_frames + 16'd1;
        end
      end else if (req != '0) begin
        m_sel        = rr_pick(req, m_lg);
        m_c          = int'(req_count[m_sel*CW +: CW]);
        m_ack[m_sel] = 1'b1;
        m_lg         = m_sel;
        m_core       = m_sel;
        m_buf        = req_buffer[m_sel*DW +: DW];
        m_cnt        = CW'((m_c > MAXC) ? MAXC : m_c);
        if (m_c > MAXC) m_sat = 1'b1;
        m_busy       = (m_c != 0);
      end else if (m_pend) begin
        m_done = 1'b1;
      end
      if (flush) m_pend = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("ack", 64'(ack), 64'(m_ack));
      check("out_valid", 64'(out_valid), 64'(m_busy));
      check("flushed", 64'(flushed), 64'(m_done));
      check("sat_err", 64'(sat_err), 64'(m_sat));
      check("frame_cnt", 64'(frame_cnt), 64'(m_frames));
      if (m_busy) begin
        check("out_buffer", 64'(out_buffer), 64'(m_buf));
        check("out_count", 64'(out_count), 64'(m_cnt));
        check("out_core", 64'(out_core), 64'(m_core));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Cores drop their request as soon as they see their ack.
  task automatic tick();
    @(negedge clk);
    req = req & ~ack;
  endtask

  task automatic set_core(input int i, input int cnt, input logic [DW-1:0] b);
    req_count[i*CW +: CW]  = CW'(cnt);
    req_buffer[i*DW +: DW] = b;
    req[i]                 = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; flush = 1'b0; out_ready = 1'b0;
    tick();
    reset = 1'b0;
    check("rst_ack", 64'(ack), 64'(0));
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_flushed", 64'(flushed), 64'(0));
    check("rst_sat", 64'(sat_err), 64'(0));
    check("rst_frames", 64'(frame_cnt), 64'(0));
    check("rst_out", 64'({out_buffer, out_count, out_core}), 64'(0));
  endtask

  task automatic test_single();
    do_reset();
    out_ready = 1'b1;
    set_core(2, 5, 30'h2AAAAAAA);
    tick();
    check("single_ack", 64'(ack), 64'(6'b000100));
    check("single_valid", 64'(out_valid), 64'(1));
    check("single_core", 64'(out_core), 64'(2));
    check("single_count", 64'(out_count), 64'(5));
    check("single_buf", 64'(out_buffer), 64'(30'h2AAAAAAA));
    tick();
    check("single_done", 64'(out_valid), 64'(0));
    check("single_frames", 64'(frame_cnt), 64'(1));
  endtask

  task automatic test_fair();
    int order[$];
    int last_t;
    last_t = -1;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) set_core(i, i + 1, DW'($urandom));
    for (int t = 0; t < 40 && order.size() < 7; t++) begin
      tick();
      if (ack != '0) begin
        check("fair_onehot", 64'($countones(ack)), 64'(1));
        for (int i = 0; i < N; i++) if (ack[i]) order.push_back(i);
        if (last_t >= 0) check("fair_gap", 64'(t - last_t), 64'(2));
        last_t = t;
      end
      req = '1;
    end
    check("fair_frames", 64'(order.size()), 64'(7));
    for (int k = 0; k < order.size(); k++) check("fair_order", 64'(order[k]), 64'(k % N));
    req = '0;
  endtask

  task automatic test_backpressure();
    logic [DW+CW+2:0] held;
    do_reset();
    set_core(0, 3, 30'h1234567);
    tick();
    set_core(1, 4, 30'h0ABCDEF);
    held = {out_buffer, out_count, out_core};
    check("bp_valid", 64'(out_valid), 64'(1));
    for (int t = 0; t < 10; t++) begin
      tick();
      check("bp_hold_valid", 64'(out_valid), 64'(1));
      check("bp_hold_ack", 64'(ack), 64'(0));
      check("bp_hold_out", 64'({out_buffer, out_count, out_core}), 64'(held));
    end
    out_ready = 1'b1;
    tick();
    check("bp_xfer_valid", 64'(out_valid), 64'(0));
    check("bp_xfer_frames", 64'(frame_cnt), 64'(1));
    tick();
    check("bp_next_ack", 64'(ack), 64'(6'b000010));
    tick();
    tick();
  endtask

  task automatic test_counts();
    do_reset();
    out_ready = 1'b1;
    set_core(3, 0, 30'h3FFFFFFF);
    tick();
    check("zero_ack", 64'(ack), 64'(6'b001000));
    check("zero_valid", 64'(out_valid), 64'(0));
    tick();
    check("zero_frames", 64'(frame_cnt), 64'(0));
    set_core(4, 15, 30'h0000FFFF);
    tick();
    check("sat_count", 64'(out_count), 64'(MAXC));
    check("sat_flag", 64'(sat_err), 64'(1));
    repeat (5) tick();
    check("sat_sticky", 64'(sat_err), 64'(1));
  endtask

  task automatic test_flush();
    int got[$];
    do_reset();
    out_ready = 1'b1;
    set_core(1, 2, 30'h11111);
    set_core(3, 4, 30'h33333);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int t = 0; t < 20 && !flushed; t++) begin
      if (out_valid && out_ready) got.push_back(int'(out_core));
      tick();
    end
    check("flush_frames", 64'(got.size()), 64'(2));
    if (got.size() == 2) begin
      check("flush_first", 64'(got[0]), 64'(1));
      check("flush_second", 64'(got[1]), 64'(3));
    end
    check("flush_done", 64'(flushed), 64'(1));
    check("flush_cnt", 64'(frame_cnt), 64'(2));
    set_core(0, 1, 30'h5);
    repeat (4) begin
      tick();
      check("flush_no_ack", 64'(ack), 64'(0));
      check("flush_no_valid", 64'(out_valid), 64'(0));
    end
    req = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_core(0, 5, 30'h77);
    tick();
    tick();
    check("mid_valid", 64'(out_valid), 64'(1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_valid", 64'(out_valid), 64'(0));
    check("mid_rst_frames", 64'(frame_cnt), 64'(0));
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) set_core(i, 2, DW'(i));
    tick();
    check("mid_first_grant", 64'(ack), 64'(6'b000001));
    req = '0;
    tick();
    tick();
  endtask

  task automatic test_wrap();
    do_reset();
    #2;
    force dut.frame_cnt = 16'hFFFF;
    m_frames = 16'hFFFF;
    #1;
    release dut.frame_cnt;
    out_ready = 1'b1;
    set_core(5, 1, 30'h9);
    tick();
    check("wrap_pre", 64'(frame_cnt), 64'(16'hFFFF));
    tick();
    check("wrap_post", 64'(frame_cnt), 64'(0));
  endtask

  task automatic test_random();
    do_reset();
    for (int t = 0; t < 3000; t++) begin
      tick();
      for (int i = 0; i < N; i++)
        if (!req[i] && $urandom_range(0, 3) == 0)
          set_core(i, int'($urandom_range(0, 15)), DW'($urandom));
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 399) == 0);
      reset     = ($urandom_range(0, 299) == 0);
    end
    reset = 1'b0;
    flush = 1'b0;
    tick();
  endtask

  initial begin
    test_single();
    test_fair();
    test_backpressure();
    test_counts();
    test_flush();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/core6_cpu_0_dct_trace_arbiter.md
CORE6_CPU_0_DCT_TRACE_ARBITER -- requirements
Module: core6_cpu_0_dct_trace_arbiter

Interface
REQ-001 SHALL have parameter NUM_CORES, default 6, number of trace requesters (1..8).
REQ-002 SHALL have parameter DCT_W, default 30, trace buffer width per frame.
REQ-003 SHALL have parameter CNT_W, default 4, width of entry count.
REQ-004 SHALL have parameter MAX_COUNT, default 10, largest legal entry count per frame.
REQ-005 SHALL have the following ports:
- clk  in  1  sole clock; all logic on rising edge.
- reset  in  1  reset; synchronous, active-high.
- req  in  NUM_CORES  per-core frame request; held until matching ack.
- req_buffer  in  NUM_CORES*DCT_W  per-core dct buffer; core i at bits [i*DCT_W +: DCT_W].
- req_count  in  NUM_CORES*CNT_W  per-core dct count, packed the same way.
- ack  out  NUM_CORES  one-cycle capture pulse to the granted core.
- out_valid  out  1  frame available to the trace sink.
- out_ready  in  1  sink accepts the frame.
- out_buffer  out  DCT_W  captured buffer.
- out_count  out  CNT_W  captured count, clamped.
- out_core  out  3  index of the source core.
- flush  in  1  test ending; drain and stop.
- flushed  out  1  test has ended; sticky.
- sat_err  out  1  sticky: some request had count > MAX_COUNT.
- frame_cnt  out  16  frames delivered; wraps.

Function
REQ-006 SHALL implement FSM states IDLE, SEND, DONE.
REQ-007 SHALL, in IDLE with req != 0, select the first asserted req strictly after last_grant, round-robin modulo NUM_CORES.
REQ-008 SHALL, on the selecting edge, register buffer, count and index into out_*, update last_grant, and set ack[sel]=1 for exactly the next cycle.
REQ-009 SHALL, for a selected count of zero, pulse ack, leave out_valid low, advance last_grant, and remain in IDLE.
REQ-010 SHALL, for a nonzero count, enter SEND with out_valid=1 in the same cycle as the ack pulse; latency is one cycle from req sampled to out_valid.
REQ-011 SHALL hold out_valid, out_buffer, out_count and out_core stable in SEND until out_ready=1 is sampled.
REQ-012 SHALL, on the transfer edge (out_valid & out_ready), drop out_valid, increment frame_cnt (0xFFFF wraps to 0x0000), and return to IDLE; back-to-back frames therefore have a one-cycle bubble.
REQ-013 SHALL ignore req while in SEND; no second ack is issued before the transfer.
REQ-014 SHALL clamp a count > MAX_COUNT to MAX_COUNT on out_count and set sat_err, which holds until reset.
REQ-015 SHALL latch flush into a sticky flush_pend bit; in-flight SEND completes normally.
REQ-016 SHALL, in IDLE with flush_pend=1 and req=0, enter DONE; while requests are pending, arbitration continues (drain).
REQ-017 SHALL, in DONE, assert flushed=1, keep ack=0 and out_valid=0, and stay in DONE until reset.
REQ-018 SHALL ignore req[i] for i >= NUM_CORES; out_core is zero-extended to 3 bits.

Reset
REQ-019 SHALL, on reset sampled high, force the following regardless of state (including mid-SEND):
- state=IDLE
- last_grant=NUM_CORES-1, so core 0 has first priority
- out_valid=0, ack=0, out_buffer=0, out_count=0, out_core=0
- flushed=0, flush_pend=0, sat_err=0, frame_cnt=0
REQ-020 SHALL give reset priority over flush, req and out_ready in the same cycle.

Verification
REQ-021 Single request: req=6'b000100, count=5, buffer=30'h2AAAAAAA, out_ready=1.
- ack[2] pulses one cycle after req sampled; out_valid rises in that same cycle.
- out_core=2, out_count=5; frame_cnt=1 after the transfer.
REQ-022 Fairness: all six req held high, out_ready=1.
- Grant order is 0,1,2,3,4,5,0; each ack pulses exactly once per frame.
- There is a one-cycle gap between frames.
REQ-023 Back-pressure: out_ready=0 for 10 cycles during SEND.
- out_* stay stable and no further acks are issued.
- Transfer completes on the first cycle with out_ready=1.
REQ-024 Boundary counts:
- count=0 -> ack, no out_valid, frame_cnt unchanged.
- count=15 -> out_count=10 and sat_err=1 until reset.
REQ-025 Flush drain: flush pulsed while cores 1 and 3 request.
- Both frames are delivered, then flushed=1.
- A later req=6'b000001 gets no ack.
REQ-026 Reset mid-SEND with out_ready=0:
- Next cycle out_valid=0, frame_cnt=0.
- A subsequent all-ones req grants core 0 first.
REQ-027 Wrap: preload 0xFFFF frames (or force frame_cnt); one more transfer gives frame_cnt=0x0000.
